// File: rtl/mcycle_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding and default datapath width.
package mcycle_muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    // MCycleOp bit positions and their encodings
    localparam int   OP_KIND_BIT = 1;
    localparam int   OP_SIGN_BIT = 0;
    localparam logic OP_MUL      = 1'b0;
    localparam logic OP_DIV      = 1'b1;
    localparam logic OP_SIGNED   = 1'b0;
    localparam logic OP_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FIXUP   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mcycle_iter_step.sv
// One combinational iteration of the muldiv datapath on a 2*WIDTH accumulator.
// Multiply: {high, multiplier}; divide: {remainder, dividend/quotient}.
module mcycle_iter_step
    import mcycle_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] trial;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        // When the subtraction succeeds the true difference is below the divisor,
        // so the low WIDTH bits are exact.
        trial    = rem_sh[WIDTH-1:0] - operand;
        acc_next = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, operand})
                acc_next = {trial, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative multiply/divide unit: Start/Busy/Done handshake, WIDTH iterations
// on operand magnitudes followed by a sign fixup cycle.
module mcycle_muldiv
    import mcycle_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic               busy_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;

    logic               start_go;
    logic               sgn_mode;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Stall must be visible in the same cycle Start is raised.
    assign start_go = (state == ST_IDLE) && Start;
    assign Busy     = busy_q | start_go;

    assign sgn_mode = (MCycleOp[OP_SIGN_BIT] == OP_SIGNED);
    assign s1       = sgn_mode & Operand1[WIDTH-1];
    assign s2       = sgn_mode & Operand2[WIDTH-1];
    // abs of the most-negative value wraps to 2^(WIDTH-1), which is the right magnitude
    assign mag1     = s1 ? -Operand1 : Operand1;
    assign mag2     = s2 ? -Operand2 : Operand2;

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = div0 ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    mcycle_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (mcand),
        .acc_next (acc_next)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            busy_q  <= 1'b0;
            Done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_div <= (MCycleOp[OP_KIND_BIT] == OP_DIV);
                        neg_q  <= s1 ^ s2;
                        neg_r  <= s1;
                        div0   <= (Operand2 == '0);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_COMPUTE;
                        if (MCycleOp[OP_KIND_BIT] == OP_DIV) begin
                            mcand <= mag2;
                            acc   <= {{WIDTH{1'b0}}, mag1};
                        end else begin
                            mcand <= mag1;
                            acc   <= {{WIDTH{1'b0}}, mag2};
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    if (op_div) begin
                        Result1 <= quot_fix;
                        Result2 <= rem_fix;
                    end else begin
                        Result1 <= prod_fix[WIDTH-1:0];
                        Result2 <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    busy_q <= 1'b0;
                    Done   <= 1'b1;
                    state  <= ST_DONE;
                end
                default: begin
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Self-checking bench for mcycle_muldiv: directed vectors, handshake corner
// cases and randomized ops against a plain-arithmetic reference model.
module tb_mcycle_muldiv;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mcycle_muldiv #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    // Reference: returns {Result2, Result1}
    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned up;
        logic [W-1:0]    q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] == 1'b0) begin
            if (op[0]) up = longint'(a) * longint'(b);
            else       up = sa * sb;
            return up;
        end
        if (b == 0) begin
            q = '1; r = a;
        end else if (op[0]) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
        end else begin
            sq = sa / sb; sr = sa % sb;
            q = sq[W-1:0]; r = sr[W-1:0];
        end
        return {r, q};
    endfunction

    // Issues one op from IDLE and watches until Done; done_at = cycle index (Start cycle = 0), -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r1, output logic [W-1:0] r2,
                          output int busy_n, output int done_at);
        busy_n = 0; done_at = -1; r1 = '0; r2 = '0;
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        #1 if (Busy) busy_n++;
        for (int c = 1; c < 200; c++) begin
            @(negedge CLK);
            Start = 1'b0; MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
            #1;
            if (Busy) busy_n++;
            if (Done) begin
                done_at = c; r1 = Result1; r2 = Result2;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (Result1 !== '0 || Result2 !== '0) begin
            errors++; $display("FAIL reset_results: got %h/%h want 0/0", Result1, Result2);
        end
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd5; Operand2 = 32'd5;
        #1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL reset_idle_start_busy: got %b want 1", Busy); end
        @(negedge CLK);
        Start = 1'b0; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start: got busy %b want 0", Busy); end
        RESET = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]   ops [6] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [W-1:0] as  [6] = '{32'd7, -32'sd3, 32'hFFFF_FFFF, -32'sd7, 32'h8000_0000, 32'd10};
        logic [W-1:0] bs  [6] = '{32'd6, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] e1  [6] = '{32'h2A, 32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] e2  [6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0000_000A};
        logic [W-1:0] r1, r2;
        int bn, da;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], r1, r2, bn, da);
            checks++; if (da !== LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, da, LAT); end
            checks++; if (bn !== LAT) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bn, LAT); end
            checks++; if (r1 !== e1[i] || r2 !== e2[i]) begin
                errors++; $display("FAIL dir%0d_result: got %h/%h want %h/%h", i, r1, r2, e1[i], e2[i]);
            end
            @(negedge CLK); #1;
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, Done); end
        end
    endtask

    task automatic test_start_ignored();
        int da = -1;
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd7; Operand2 = 32'd6;
        for (int c = 1; c < 200; c++) begin
            @(negedge CLK);
            Start = (c == 3); MCycleOp = 2'b00; Operand1 = 32'd100; Operand2 = 32'd99;
            #1;
            if (Done) begin da = c; break; end
        end
        Start = 1'b0;
        checks++; if (da !== LAT) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", da, LAT); end
        checks++; if (Result1 !== 32'h2A || Result2 !== 32'h0) begin
            errors++; $display("FAIL busy_start_result: got %h/%h want 0000002a/00000000", Result1, Result2);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] r1, r2;
        int bn, da;
        int stray = 0;
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd7; Operand2 = 32'd6;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got busy %b done %b want 0 0", Busy, Done);
        end
        checks++; if (Result1 !== '0 || Result2 !== '0) begin
            errors++; $display("FAIL midreset_results: got %h/%h want 0/0", Result1, Result2);
        end
        repeat (40) begin
            @(negedge CLK); #1;
            if (Done || Busy) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midreset_abandon: got %0d active cycles want 0", stray); end
        run_op(2'b01, 32'd2, 32'd3, r1, r2, bn, da);
        checks++; if (r1 !== 32'd6 || r2 !== 32'd0) begin
            errors++; $display("FAIL midreset_fresh_result: got %h/%h want 6/0", r1, r2);
        end
        checks++; if (da !== LAT) begin errors++; $display("FAIL midreset_fresh_latency: got %0d want %0d", da, LAT); end
    endtask

    task automatic test_start_in_done();
        logic [W-1:0] r1, r2;
        int bn, da;
        int stray = 0;
        run_op(2'b01, 32'd9, 32'd9, r1, r2, bn, da);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd5; Operand2 = 32'd5;
        @(negedge CLK);
        Start = 1'b0; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b want 0", Busy); end
        repeat (40) begin
            @(negedge CLK); #1;
            if (Done || Busy) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL done_start_ignored: got %0d active cycles want 0", stray); end
        checks++; if (Result1 !== 32'd81 || Result2 !== 32'd0) begin
            errors++; $display("FAIL done_start_hold: got %h/%h want 51/0", Result1, Result2);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random(input int n);
        logic [W-1:0]   a, b, r1, r2;
        logic [1:0]     op;
        logic [2*W-1:0] exp;
        int bn, da;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom); a = pick(); b = pick();
            exp = model(op, a, b);
            run_op(op, a, b, r1, r2, bn, da);
            checks++; if (da !== LAT || bn !== LAT) begin
                errors++; $display("FAIL rnd%0d_timing: got done@%0d busy %0d want %0d", i, da, bn, LAT);
            end
            checks++; if ({r2, r1} !== exp) begin
                errors++; $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h/%h want %h/%h",
                                   i, op, a, b, r1, r2, exp[W-1:0], exp[2*W-1:W]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2;
        int bn, da;
        test_random(8);
        r1 = Result1; r2 = Result2;
        repeat (5) @(negedge CLK);
        #1;
        checks++; if (Result1 !== r1 || Result2 !== r2) begin
            errors++; $display("FAIL b2b_hold: got %h/%h want %h/%h", Result1, Result2, r1, r2);
        end
        run_op(2'b11, 32'd100, 32'd7, r1, r2, bn, da);
        checks++; if (r1 !== 32'd14 || r2 !== 32'd2) begin
            errors++; $display("FAIL b2b_udiv: got %h/%h want e/2", r1, r2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_midop();
        test_start_in_done();
        test_back_to_back();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcycle_muldiv.md
Name: mcycle_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit for execute stage E.
- Responder side of the M_Start/M_Done handshake: accepts a one-cycle Start from E, holds Busy to stall the pipeline, returns results with a one-cycle Done pulse.
- The pipeline-side capture register restores the saved instruction context and selects Result1 as the E-stage op result when Done is high.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count per operation.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- MCycleOp  input  2  bit1: 0=multiply, 1=divide; bit0: 0=signed, 1=unsigned.
- Operand1  input  WIDTH  multiplicand / dividend; sampled with Start.
- Operand2  input  WIDTH  multiplier / divisor; sampled with Start.
- Result1  output  WIDTH  product low half / quotient.
- Result2  output  WIDTH  product high half / remainder.
- Busy  output  1  pipeline stall request.
- Done  output  1  one-cycle result-valid pulse.

Behaviour:
- Reset: synchronous only, evaluated at the rising edge of CLK, priority over everything.
  - State goes to IDLE.
  - Result1, Result2, counter and internal registers go to 0.
  - Done goes to 0. Busy goes to 0 unless Start is high in IDLE.
  - A reset in mid-operation abandons the operation; no Done is issued.
- States: IDLE, COMPUTE, FIXUP, DONE.
- IDLE:
  - Busy = Start, combinational, so the stall is seen in the same cycle as the start.
  - On an edge with Start=1: latch the op, the operand magnitudes (signed mode: take abs, record the result signs), clear the accumulator, set counter=0, go to COMPUTE.
- COMPUTE:
  - Busy=1. One iteration per edge; counter increments.
  - Multiply: shift-add of a 2*WIDTH accumulator.
  - Divide: restoring trial subtraction, one quotient bit per edge.
  - After iteration WIDTH-1 (counter==WIDTH-1), go to FIXUP.
- FIXUP:
  - Busy=1.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient takes sign(Op1) XOR sign(Op2); remainder takes sign(Op1).
  - Load Result1/Result2. Go to DONE.
- DONE:
  - Busy=0, Done=1 for exactly this one cycle; next edge goes to IDLE.
  - Start in DONE is ignored; the pipeline re-issues Start only from IDLE.
- Latency: Start sampled at edge E0; Done=1 in the cycle after edge E0+WIDTH+1. Busy=1 for WIDTH+2 cycles, counting the Start cycle.
- Result1/Result2 hold their value from FIXUP until the next FIXUP or reset.
- Start while Busy (COMPUTE/FIXUP) is ignored; operands are not re-sampled.
- Divide by zero, signed or unsigned: Result1 = all ones, Result2 = Operand1. No exception is raised; latency is unchanged.
- Signed overflow (Op1 = most-negative, Op2 = -1): Result1 = most-negative, Result2 = 0.
- Signed abs of the most-negative value is treated as unsigned 2^(WIDTH-1); this is correct with no special case.
- Unsigned mode: operands are used as-is; no fixup negation.
- All arithmetic is modulo 2^WIDTH per result half.

Decomposition:
- Shared package holds:
  - MCycleOp bit positions and encodings (OP_MUL, OP_DIV, OP_SIGNED, OP_UNSIGNED).
  - State encoding (2-bit).
  - Default WIDTH.
- One sub-module, mcycle_iter_step: purely combinational single iteration.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract plus quotient bit.
  - Instantiated once; the top holds the FSM, counter and sign fixup.

Test Plan:
- Unsigned mul 7 x 6, MCycleOp=2'b01 -> Busy high 34 cycles from the Start cycle; Done pulse 1 cycle; Result1=0x0000002A, Result2=0x00000000.
- Signed mul -3 x 5 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
- Unsigned mul 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE.
- Signed div -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
- Signed div 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
- Unsigned div 10 / 0 -> Result1=0xFFFFFFFF, Result2=0x0000000A.
- Start 7x6, then at cycle 3 pulse Start again with different operands -> ignored; Result1=0x2A at Done.
- Start 7x6, assert RESET at cycle 10 -> next cycle Busy=0, Done=0, Result1=Result2=0, state IDLE. A fresh 2x3 afterwards gives Result1=6 with full latency.
